// File: rtl/fi_campaign_ctrl.sv
// fi_campaign_ctrl: self-running fault-injection sweep that launches DUT/reference AES runs and classifies each one
// Build option: define FI_CAMPAIGN_MODE_SWEEP_EN to sweep bit/byte mode as the outermost loop (esc_info gains mode as MSB)
module fi_campaign_ctrl #(
    parameter int N_FUNC    = 4,
    parameter int MAX_ROUND = 9,
    parameter int TIMEOUT   = 63,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_sel,
    input  logic [3:0]       bit_sel,
    input  logic             done,
    input  logic             done_ref,
    input  logic [127:0]     text_out,
    input  logic [127:0]     text_out_ref,
    input  logic             fault_detected,
    input  logic [4:0]       fault_location,
    output logic             ld,
    output logic             en_FI,
    output logic             mode_FI,
    output logic [3:0]       func_FI,
    output logic [3:0]       round_FI,
    output logic [3:0]       bit_index_FI,
    output logic [1:0]       row_FI,
    output logic [1:0]       column_FI,
    output logic             busy,
    output logic             campaign_done,
    output logic [CNT_W-1:0] n_runs,
    output logic [CNT_W-1:0] n_detected,
    output logic [CNT_W-1:0] n_escaped,
    output logic [CNT_W-1:0] n_masked,
    output logic [CNT_W-1:0] n_false,
    output logic [CNT_W-1:0] n_locerr,
    output logic [CNT_W-1:0] n_timeout,
    output logic             esc_valid,
`ifdef FI_CAMPAIGN_MODE_SWEEP_EN
    output logic [12:0]      esc_info
`else
    output logic [11:0]      esc_info
`endif
);
    localparam int WC_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, NEXT, FIN} state_t;

    state_t            state, state_n;
    logic              d_seen, r_seen, f_seen;
    logic [WC_W-1:0]   wcnt;
    logic [127:0]      txt_d, txt_r;
    logic [4:0]        loc;
    logic              got_both, wait_expired, last_idx, last_site, mis;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next-state decode, status outputs and run-completion conditions
    always_comb begin
        got_both     = (d_seen | done) & (r_seen | done_ref);
        wait_expired = wcnt == WC_W'(TIMEOUT);
        last_idx     = func_FI == 4'(N_FUNC - 1) && round_FI == 4'(MAX_ROUND) && row_FI == 2'd3 && column_FI == 2'd3;
`ifdef FI_CAMPAIGN_MODE_SWEEP_EN
        last_site    = last_idx & mode_FI;
`else
        last_site    = last_idx;
`endif
        mis          = txt_d != txt_r;
        state_n      = state;
        case (state)
            IDLE, FIN: state_n = start ? LOAD : state;
            LOAD:      state_n = WAIT;
            WAIT:      state_n = got_both ? CHECK : (wait_expired ? NEXT : WAIT);
            CHECK:     state_n = NEXT;
            NEXT:      state_n = last_site ? FIN : LOAD;
            default:   state_n = IDLE;
        endcase
        ld            = state == LOAD;
        en_FI         = state == LOAD || state == WAIT || state == CHECK;
        busy          = state != IDLE && state != FIN;
        campaign_done = state == FIN;
    end

    // sweep indices, per-run capture and result counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_seen       <= 1'b0;
            r_seen       <= 1'b0;
            f_seen       <= 1'b0;
            wcnt         <= '0;
            txt_d        <= '0;
            txt_r        <= '0;
            loc          <= '0;
            mode_FI      <= 1'b0;
            func_FI      <= '0;
            round_FI     <= '0;
            row_FI       <= '0;
            column_FI    <= '0;
            bit_index_FI <= '0;
            n_runs       <= '0;
            n_detected   <= '0;
            n_escaped    <= '0;
            n_masked     <= '0;
            n_false      <= '0;
            n_locerr     <= '0;
            n_timeout    <= '0;
            esc_valid    <= 1'b0;
            esc_info     <= '0;
        end else begin
            case (state)
                IDLE, FIN: if (start) begin
                    n_runs       <= '0;
                    n_detected   <= '0;
                    n_escaped    <= '0;
                    n_masked     <= '0;
                    n_false      <= '0;
                    n_locerr     <= '0;
                    n_timeout    <= '0;
                    esc_valid    <= 1'b0;
                    esc_info     <= '0;
                    func_FI      <= '0;
                    round_FI     <= '0;
                    row_FI       <= '0;
                    column_FI    <= '0;
                    bit_index_FI <= bit_sel;
`ifdef FI_CAMPAIGN_MODE_SWEEP_EN
                    mode_FI      <= 1'b0;
`else
                    mode_FI      <= mode_sel;
`endif
                end
                LOAD: begin
                    d_seen <= 1'b0;
                    r_seen <= 1'b0;
                    f_seen <= 1'b0;
                    wcnt   <= '0;
                end
                WAIT: begin
                    if (done) begin
                        d_seen <= 1'b1;
                        txt_d  <= text_out;
                    end
                    if (done_ref) begin
                        r_seen <= 1'b1;
                        txt_r  <= text_out_ref;
                    end
                    if (fault_detected) begin
                        f_seen <= 1'b1;
                        loc    <= fault_location;
                    end
                    if (!got_both && wait_expired) n_timeout <= sat_inc(n_timeout);
                    wcnt <= wcnt + 1'b1;
                end
                CHECK: begin
                    if (f_seen && mis) n_detected <= sat_inc(n_detected);
                    if (!f_seen && mis) begin
                        n_escaped <= sat_inc(n_escaped);
                        if (!esc_valid) begin
                            esc_valid <= 1'b1;
`ifdef FI_CAMPAIGN_MODE_SWEEP_EN
                            esc_info  <= {mode_FI, func_FI, round_FI, row_FI, column_FI};
`else
                            esc_info  <= {func_FI, round_FI, row_FI, column_FI};
`endif
                        end
                    end
                    if (!f_seen && !mis) n_masked <= sat_inc(n_masked);
                    if (f_seen && !mis) n_false <= sat_inc(n_false);
                    if (f_seen && loc != 5'(round_FI) + 5'd1) n_locerr <= sat_inc(n_locerr);
                end
                NEXT: begin
                    n_runs <= sat_inc(n_runs);
                    if (!last_site) begin
                        column_FI <= column_FI + 2'd1;
                        if (column_FI == 2'd3) begin
                            row_FI <= row_FI + 2'd1;
                            if (row_FI == 2'd3) begin
                                round_FI <= round_FI == 4'(MAX_ROUND) ? 4'd0 : round_FI + 4'd1;
                                if (round_FI == 4'(MAX_ROUND)) begin
                                    func_FI <= func_FI == 4'(N_FUNC - 1) ? 4'd0 : func_FI + 4'd1;
`ifdef FI_CAMPAIGN_MODE_SWEEP_EN
                                    if (func_FI == 4'(N_FUNC - 1)) mode_FI <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
